// File: rtl/vector_alu_seq_if.sv
// Sequencer <-> vector ALU handshake and operand/result bus.
interface vector_alu_seq_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned LANES = 2
);
  logic             start;
  logic [4:0]       ALU_Op;
  logic [WIDTH-1:0] R;
  logic [WIDTH-1:0] S;
  logic [WIDTH-1:0] Y;
  logic [LANES-1:0] co;
  logic             busy;
  logic             done;

  // Sequencer side: issues requests, observes results
  modport master (
    output start, ALU_Op, R, S,
    input  Y, co, busy, done
  );

  // ALU side: accepts requests, produces results
  modport slave (
    input  start, ALU_Op, R, S,
    output Y, co, busy, done
  );
endinterface

// File: rtl/vector_alu_seq.sv
// Registered lane-split vector ALU: single-cycle add/sub/logic, iterative
// shift-add unsigned multiply (one multiplier bit per clock per lane).
module vector_alu_seq #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned LANES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  vector_alu_seq_if.slave   bus
);

  localparam int unsigned LANE_W = WIDTH / LANES;
  localparam int unsigned ACC_W  = 2 * LANE_W;
  localparam int unsigned CNT_W  = $clog2(LANE_W) + 1;

  localparam logic [4:0] OP_ADD  = 5'b01010;
  localparam logic [4:0] OP_SUB  = 5'b01011;
  localparam logic [4:0] OP_AND  = 5'b01100;
  localparam logic [4:0] OP_OR   = 5'b01101;
  localparam logic [4:0] OP_XOR  = 5'b01110;
  localparam logic [4:0] OP_MUL  = 5'b10000;
  localparam logic [4:0] OP_MULH = 5'b10001;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                            state_q, state_d;
  logic [WIDTH-1:0]                  y_q, y_d;
  logic [LANES-1:0]                  co_q, co_d;
  logic                              done_q, done_d;
  logic                              busy_q, busy_d;
  logic                              mulh_q, mulh_d;
  logic [CNT_W-1:0]                  cnt_q, cnt_d;
  logic [LANES-1:0][ACC_W-1:0]       acc_q, acc_d;
  logic [LANES-1:0][ACC_W-1:0]       mcand_q, mcand_d;
  logic [LANES-1:0][LANE_W-1:0]      mplier_q, mplier_d;

  logic [WIDTH-1:0]                  alu_y_c;
  logic [LANES-1:0]                  alu_co_c;
  logic [LANES-1:0][ACC_W-1:0]       acc_step_c;
  logic                              is_mul_c;

  // Single-cycle lane-wise result for every non-multiply opcode
  always_comb begin
    logic [LANE_W-1:0] a;
    logic [LANE_W-1:0] b;
    logic [LANE_W:0]   ext;
    alu_y_c  = '0;
    alu_co_c = '0;
    a        = '0;
    b        = '0;
    ext      = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      a = bus.R[i*LANE_W +: LANE_W];
      b = bus.S[i*LANE_W +: LANE_W];
      case (bus.ALU_Op)
        OP_ADD: begin
          ext                        = {1'b0, a} + {1'b0, b};
          alu_y_c[i*LANE_W +: LANE_W] = ext[LANE_W-1:0];
          alu_co_c[i]                = ext[LANE_W];
        end
        OP_SUB: begin
          // Extended subtraction: top bit is set exactly when a < b
          ext                        = {1'b0, a} - {1'b0, b};
          alu_y_c[i*LANE_W +: LANE_W] = ext[LANE_W-1:0];
          alu_co_c[i]                = ext[LANE_W];
        end
        OP_AND:  alu_y_c[i*LANE_W +: LANE_W] = a & b;
        OP_OR:   alu_y_c[i*LANE_W +: LANE_W] = a | b;
        OP_XOR:  alu_y_c[i*LANE_W +: LANE_W] = a ^ b;
        default: alu_y_c[i*LANE_W +: LANE_W] = b;
      endcase
    end
  end

  // One shift-add partial-product accumulation per lane
  always_comb begin
    acc_step_c = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      acc_step_c[i] = mplier_q[i][0] ? (acc_q[i] + mcand_q[i]) : acc_q[i];
    end
  end

  assign is_mul_c = (bus.ALU_Op == OP_MUL) || (bus.ALU_Op == OP_MULH);

  // Next-state and datapath-register update
  always_comb begin
    state_d  = state_q;
    y_d      = y_q;
    co_d     = co_q;
    done_d   = 1'b0;
    busy_d   = busy_q;
    mulh_d   = mulh_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (bus.start) begin
          if (is_mul_c) begin
            for (int i = 0; i < int'(LANES); i++) begin
              mcand_d[i]  = ACC_W'(bus.R[i*LANE_W +: LANE_W]);
              mplier_d[i] = bus.S[i*LANE_W +: LANE_W];
            end
            acc_d   = '0;
            cnt_d   = '0;
            mulh_d  = (bus.ALU_Op == OP_MULH);
            busy_d  = 1'b1;
            state_d = S_MUL;
          end else begin
            y_d     = alu_y_c;
            co_d    = alu_co_c;
            done_d  = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_MUL: begin
        acc_d = acc_step_c;
        for (int i = 0; i < int'(LANES); i++) begin
          mcand_d[i]  = mcand_q[i] << 1;
          mplier_d[i] = mplier_q[i] >> 1;
        end
        cnt_d = cnt_q + CNT_W'(1);
        // This edge retires the last multiplier bit
        if (cnt_q == CNT_W'(LANE_W - 1)) begin
          for (int i = 0; i < int'(LANES); i++) begin
            y_d[i*LANE_W +: LANE_W] = mulh_q ? acc_step_c[i][ACC_W-1:LANE_W]
                                             : acc_step_c[i][LANE_W-1:0];
          end
          co_d    = '0;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any multiply in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      y_q      <= '0;
      co_q     <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      mulh_q   <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else begin
      state_q  <= state_d;
      y_q      <= y_d;
      co_q     <= co_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      mulh_q   <= mulh_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
    end
  end

  assign bus.Y    = y_q;
  assign bus.co   = co_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_vector_alu_seq.sv
// Directed bench for vector_alu_seq: 16-bit/2-lane and 32-bit/1-lane builds.
module tb_vector_alu_seq;

  localparam logic [4:0] OP_ADD  = 5'b01010;
  localparam logic [4:0] OP_SUB  = 5'b01011;
  localparam logic [4:0] OP_AND  = 5'b01100;
  localparam logic [4:0] OP_OR   = 5'b01101;
  localparam logic [4:0] OP_XOR  = 5'b01110;
  localparam logic [4:0] OP_MUL  = 5'b10000;
  localparam logic [4:0] OP_MULH = 5'b10001;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  // Scoreboard entries for the 16-bit build: {Y, co}
  logic [17:0] exp_q[$];

  vector_alu_seq_if #(.WIDTH(16), .LANES(2)) ifa ();
  vector_alu_seq_if #(.WIDTH(32), .LANES(1)) ifb ();

  vector_alu_seq #(.WIDTH(16), .LANES(2)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  vector_alu_seq #(.WIDTH(32), .LANES(1)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model, 8-bit lanes, written with native operators
  function automatic logic [17:0] model_a(input logic [4:0] op, input logic [15:0] r,
                                           input logic [15:0] s);
    logic [15:0] y;
    logic [1:0]  co;
    logic [7:0]  a, b;
    logic [8:0]  t;
    logic [15:0] p;
    y = '0; co = '0;
    for (int i = 0; i < 2; i++) begin
      a = r[i*8 +: 8];
      b = s[i*8 +: 8];
      p = 16'(a) * 16'(b);
      case (op)
        OP_ADD:  begin t = 9'(a) + 9'(b); y[i*8 +: 8] = t[7:0]; co[i] = t[8]; end
        OP_SUB:  begin y[i*8 +: 8] = a - b; co[i] = (a < b); end
        OP_AND:  y[i*8 +: 8] = a & b;
        OP_OR:   y[i*8 +: 8] = a | b;
        OP_XOR:  y[i*8 +: 8] = a ^ b;
        OP_MUL:  y[i*8 +: 8] = p[7:0];
        OP_MULH: y[i*8 +: 8] = p[15:8];
        default: y[i*8 +: 8] = b;
      endcase
    end
    return {y, co};
  endfunction

  // Present one request for exactly one accepting edge; returns at edge+1
  task automatic start_a(input logic [4:0] op, input logic [15:0] r, input logic [15:0] s,
                         input bit push);
    @(negedge clk);
    ifa.start = 1'b1; ifa.ALU_Op = op; ifa.R = r; ifa.S = s;
    if (push) exp_q.push_back(model_a(op, r, s));
    @(posedge clk); #1;
    ifa.start = 1'b0;
  endtask

  // Wait (bounded) for done, counting edges and busy cycles, then score
  task automatic wait_done_a(input string tag, input int max, output int lat, output int bcnt);
    logic [17:0] e;
    lat = 0; bcnt = 0;
    while (!ifa.done && lat < max) begin
      bcnt += ifa.busy ? 1 : 0;
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_done"}, 64'(ifa.done), 64'(1));
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({tag, "_y"},  64'(ifa.Y),  64'(e[17:2]));
      check({tag, "_co"}, 64'(ifa.co), 64'(e[1:0]));
    end else begin
      check({tag, "_sb_nonempty"}, 64'(0), 64'(1));
    end
  endtask

  task automatic start_b(input logic [4:0] op, input logic [31:0] r, input logic [31:0] s);
    @(negedge clk);
    ifb.start = 1'b1; ifb.ALU_Op = op; ifb.R = r; ifb.S = s;
    @(posedge clk); #1;
    ifb.start = 1'b0;
  endtask

  task automatic wait_done_b(input string tag, input int max, input logic [31:0] ey,
                             input logic ec, output int lat);
    lat = 0;
    while (!ifb.done && lat < max) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_done"}, 64'(ifb.done), 64'(1));
    check({tag, "_y"},    64'(ifb.Y),    64'(ey));
    check({tag, "_co"},   64'(ifb.co),   64'(ec));
  endtask

  initial begin
    int lat, bcnt, ndone;
    logic [15:0] hold_y;
    logic [15:0] rr, ss;
    checks = 0; failures = 0;
    ifa.start = 1'b0; ifa.ALU_Op = '0; ifa.R = '0; ifa.S = '0;
    ifb.start = 1'b0; ifb.ALU_Op = '0; ifb.R = '0; ifb.S = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_y",    64'(ifa.Y),    64'(0));
    check("rst_co",   64'(ifa.co),   64'(0));
    check("rst_busy", 64'(ifa.busy), 64'(0));
    check("rst_done", 64'(ifa.done), 64'(0));
    check("rst_b_y",  64'(ifb.Y),    64'(0));
    @(negedge clk); rst_n = 1'b1;

    // ADD with lane-0 carry, one-cycle latency
    start_a(OP_ADD, 16'h12F0, 16'h0120, 1'b1);
    check("add_busy", 64'(ifa.busy), 64'(0));
    wait_done_a("add", 20, lat, bcnt);
    check("add_lat", 64'(lat), 64'(0));
    check("add_lit", 64'(ifa.Y), 64'(16'h1310));
    @(posedge clk); #1;
    check("add_done_once", 64'(ifa.done), 64'(0));

    // SUB with borrow in both lanes, then pass-through default op
    start_a(OP_SUB, 16'h0510, 16'h0620, 1'b1);
    wait_done_a("sub", 20, lat, bcnt);
    check("sub_co_lit", 64'(ifa.co), 64'(2'b11));
    start_a(5'b00000, 16'h1234, 16'hABCD, 1'b1);
    wait_done_a("pass", 20, lat, bcnt);

    // Logic ops
    start_a(OP_AND, 16'hF0CC, 16'h3CAA, 1'b1); wait_done_a("and", 20, lat, bcnt);
    start_a(OP_OR,  16'hF0CC, 16'h3CAA, 1'b1); wait_done_a("or",  20, lat, bcnt);
    start_a(OP_XOR, 16'hF0CC, 16'h3CAA, 1'b1); wait_done_a("xor", 20, lat, bcnt);

    // MUL: 8 busy cycles, done on the 9th cycle after start
    start_a(OP_MUL, 16'h0310, 16'h0405, 1'b1);
    check("mul_busy_hi", 64'(ifa.busy), 64'(1));
    wait_done_a("mul", 40, lat, bcnt);
    check("mul_lat",  64'(lat),  64'(8));
    check("mul_busy_cycles", 64'(bcnt), 64'(8));
    check("mul_busy_lo", 64'(ifa.busy), 64'(0));
    check("mul_lit", 64'(ifa.Y), 64'(16'h0C50));

    // MULH with an ADD start injected mid-operation (must be ignored)
    start_a(OP_MULH, 16'hFF10, 16'hFF20, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    ifa.start = 1'b1; ifa.ALU_Op = OP_ADD; ifa.R = 16'h1111; ifa.S = 16'h2222;
    @(posedge clk); #1;
    ifa.start = 1'b0;
    check("mulh_inject_busy", 64'(ifa.busy), 64'(1));
    wait_done_a("mulh", 40, lat, bcnt);
    check("mulh_lat_rest", 64'(lat), 64'(5));
    check("mulh_lit", 64'(ifa.Y), 64'(16'hFE02));
    ndone = 0;
    repeat (10) begin @(posedge clk); #1; ndone += ifa.done ? 1 : 0; end
    check("mulh_single_done", 64'(ndone), 64'(0));

    // Random-operand multiplies against the native-multiply model
    for (int k = 0; k < 3; k++) begin
      rr = 16'($urandom); ss = 16'($urandom);
      start_a((k % 2 == 0) ? OP_MUL : OP_MULH, rr, ss, 1'b1);
      wait_done_a("mul_rand", 40, lat, bcnt);
    end

    // Back-to-back: start held through DONE accepts a second op
    @(negedge clk);
    ifa.start = 1'b1; ifa.ALU_Op = OP_ADD; ifa.R = 16'h80FF; ifa.S = 16'h8001;
    exp_q.push_back(model_a(OP_ADD, 16'h80FF, 16'h8001));
    @(posedge clk); #1;
    wait_done_a("b2b_add", 2, lat, bcnt);
    ifa.ALU_Op = OP_XOR; ifa.R = 16'h5A5A; ifa.S = 16'hFF00;
    exp_q.push_back(model_a(OP_XOR, 16'h5A5A, 16'hFF00));
    @(posedge clk); #1;
    ifa.start = 1'b0;
    wait_done_a("b2b_xor", 2, lat, bcnt);
    check("b2b_lat", 64'(lat), 64'(0));

    // Result holds while inputs wiggle without start
    hold_y = ifa.Y;
    @(negedge clk);
    ifa.ALU_Op = OP_ADD; ifa.R = 16'hFFFF; ifa.S = 16'hFFFF;
    repeat (3) @(posedge clk);
    #1;
    check("hold_y",    64'(ifa.Y),    64'(hold_y));
    check("hold_co",   64'(ifa.co),   64'(0));
    check("hold_done", 64'(ifa.done), 64'(0));

    // Asynchronous reset three cycles into a MUL
    start_a(OP_MUL, 16'hFFFF, 16'hFFFF, 1'b0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_y",    64'(ifa.Y),    64'(0));
    check("arst_busy", 64'(ifa.busy), 64'(0));
    check("arst_done", 64'(ifa.done), 64'(0));
    @(negedge clk); rst_n = 1'b1;
    ndone = 0;
    repeat (15) begin @(posedge clk); #1; ndone += ifa.done ? 1 : 0; end
    check("arst_no_done", 64'(ndone), 64'(0));
    check("arst_idle_busy", 64'(ifa.busy), 64'(0));

    // 32-bit single-lane build
    start_b(OP_ADD, 32'hFFFF_FFFF, 32'h0000_0001);
    wait_done_b("b_add", 5, 32'h0, 1'b1, lat);
    start_b(OP_MUL, 32'h0001_0000, 32'h0001_0000);
    wait_done_b("b_mul", 80, 32'h0, 1'b0, lat);
    check("b_mul_lat", 64'(lat), 64'(32));
    start_b(OP_MULH, 32'h0001_0000, 32'h0001_0000);
    wait_done_b("b_mulh", 80, 32'h1, 1'b0, lat);

    check("sb_empty", 64'(exp_q.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
